// File: rtl/mem_loader_pkg.sv
// mem_loader_pkg: shared types and constants for the boot memory loader.
// Holds the loader FSM state encoding and the stream header length.
package mem_loader_pkg;

    typedef enum logic [2:0] {
        HDR_LO,
        HDR_HI,
        DATA,
        WRITE,
        DONE
    } state_t;

    // Word count header: low byte then high byte.
    localparam int HDR_BYTES = 2;

    // Width of a byte-lane index for a word of n bytes (at least 1 bit).
    function automatic int lane_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_loader_byte_packer.sv
// byte_packer: assembles a memory word from bytes written into lanes.
// Ports: clk, reset (sync, active-high), i_en (write strobe),
//        i_lane (byte lane index), i_byte (byte in), o_word (word out).
module byte_packer
    import mem_loader_pkg::*;
#(
    parameter int NUM_WMASKS = 4,
    parameter int DATA_WIDTH = 32,
    parameter int LANE_W     = lane_bits(NUM_WMASKS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_en,
    input  logic [LANE_W-1:0]     i_lane,
    input  logic [7:0]            i_byte,
    output logic [DATA_WIDTH-1:0] o_word
);

    logic [DATA_WIDTH-1:0] r_word;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_word <= '0;
        end else if (i_en) begin
            r_word[8*i_lane +: 8] <= i_byte;
        end
    end

    assign o_word = r_word;

endmodule

// File: rtl/mem_loader.sv
// mem_loader: loads a byte stream (16-bit word count, then LSB-first words)
// into memory while holding the CPU in reset, then releases the memory port.
// Ports: clk, reset (sync, active-high), skip_load, rx_data/rx_valid/rx_ready
//        (byte stream), port_select, mem_web/mem_wmask/mem_addr/mem_din
//        (memory write port), cpu_reset, done.
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int NUM_WMASKS = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  skip_load,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  port_select,
    output logic                  mem_web,
    output logic [NUM_WMASKS-1:0] mem_wmask,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    output logic                  cpu_reset,
    output logic                  done
);

    localparam int LANE_W = lane_bits(NUM_WMASKS);
    localparam int CNT_W  = ADDR_WIDTH + 1;
    localparam logic [31:0] MAX_WORDS = 32'(1) << ADDR_WIDTH;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_WMASKS - 1);

    state_t                r_state;
    logic [7:0]            r_cnt_lo;
    logic [CNT_W-1:0]      r_count;
    logic [CNT_W-1:0]      r_widx;
    logic [LANE_W-1:0]     r_bidx;

    logic                  w_xfer;
    logic [15:0]           w_hdr_n;
    logic [CNT_W-1:0]      w_eff;
    logic [CNT_W-1:0]      w_widx_nx;
    logic [DATA_WIDTH-1:0] w_word;

    assign w_xfer    = rx_valid && rx_ready;
    assign w_hdr_n   = {rx_data, r_cnt_lo};
    assign w_widx_nx = r_widx + CNT_W'(1);

    // Clamp the header count to the memory depth.
    always_comb begin
        w_eff = CNT_W'(w_hdr_n);
        if (32'(w_hdr_n) > MAX_WORDS) begin
            w_eff = CNT_W'(MAX_WORDS);
        end
    end

    byte_packer #(
        .NUM_WMASKS (NUM_WMASKS),
        .DATA_WIDTH (DATA_WIDTH),
        .LANE_W     (LANE_W)
    ) u_packer (
        .clk    (clk),
        .reset  (reset),
        .i_en   (w_xfer && (r_state == DATA)),
        .i_lane (r_bidx),
        .i_byte (rx_data),
        .o_word (w_word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= HDR_LO;
            r_cnt_lo <= '0;
            r_count  <= '0;
            r_widx   <= '0;
            r_bidx   <= '0;
        end else begin
            unique case (r_state)
                HDR_LO: begin
                    if (skip_load) begin
                        r_state <= DONE;
                    end else if (rx_valid) begin
                        r_cnt_lo <= rx_data;
                        r_state  <= HDR_HI;
                    end
                end
                HDR_HI: begin
                    if (rx_valid) begin
                        r_count <= w_eff;
                        r_widx  <= '0;
                        r_bidx  <= '0;
                        r_state <= (w_eff == '0) ? DONE : DATA;
                    end
                end
                DATA: begin
                    if (rx_valid) begin
                        if (r_bidx == LAST_LANE) begin
                            r_state <= WRITE;
                        end else begin
                            r_bidx <= r_bidx + LANE_W'(1);
                        end
                    end
                end
                WRITE: begin
                    r_widx  <= w_widx_nx;
                    r_bidx  <= '0;
                    r_state <= (w_widx_nx == r_count) ? DONE : DATA;
                end
                DONE: begin
                    r_state <= DONE;
                end
                default: begin
                    r_state <= HDR_LO;
                end
            endcase
        end
    end

    // Outputs decoded from the state register and held data registers.
    always_comb begin
        rx_ready    = 1'b0;
        port_select = 1'b1;
        cpu_reset   = 1'b1;
        done        = 1'b0;
        mem_web     = 1'b1;
        mem_wmask   = '0;
        mem_addr    = '0;
        mem_din     = '0;
        unique case (r_state)
            HDR_LO: rx_ready = !skip_load;
            HDR_HI: rx_ready = 1'b1;
            DATA:   rx_ready = 1'b1;
            WRITE: begin
                mem_web   = 1'b0;
                mem_wmask = '1;
                mem_addr  = r_widx[ADDR_WIDTH-1:0];
                mem_din   = w_word;
            end
            DONE: begin
                port_select = 1'b0;
                cpu_reset   = 1'b0;
                done        = 1'b1;
            end
            default: begin
                rx_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: directed self-checking bench for mem_loader.
// Drives byte streams, records memory writes on the falling edge.
module tb_mem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        skip_load;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        port_select;
    logic        mem_web;
    logic [3:0]  mem_wmask;
    logic [10:0] mem_addr;
    logic [31:0] mem_din;
    logic        cpu_reset;
    logic        done;

    int n_checks = 0;
    int n_errs   = 0;

    logic [10:0] wa[$];
    logic [31:0] wd[$];
    logic [3:0]  wm[$];

    mem_loader dut (
        .clk         (clk),
        .reset       (reset),
        .skip_load   (skip_load),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .port_select (port_select),
        .mem_web     (mem_web),
        .mem_wmask   (mem_wmask),
        .mem_addr    (mem_addr),
        .mem_din     (mem_din),
        .cpu_reset   (cpu_reset),
        .done        (done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset && !mem_web) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_din);
            wm.push_back(mem_wmask);
        end
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        wa.delete();
        wd.delete();
        wm.delete();
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        int n;
        for (int g = 0; g < gap; g++) begin
            rx_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b1;
        rx_data  = b;
        n = 0;
        while (!rx_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!rx_ready) check("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("wait_done", done, 1'b1);
    endtask

    initial begin
        int ea;
        int ed;
        logic [7:0] s1[10];
        logic [7:0] s3[14];
        logic [7:0] b;

        skip_load = 1'b0;
        reset     = 1'b1;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;

        // Reset state
        do_reset();
        check("rst_psel", port_select, 1'b1);
        check("rst_cpurst", cpu_reset, 1'b1);
        check("rst_done", done, 1'b0);
        check("rst_web", mem_web, 1'b1);
        check("rst_wmask", mem_wmask, 4'h0);
        check("rst_addr", mem_addr, 11'h0);
        check("rst_din", mem_din, 32'h0);
        check("rst_ready", rx_ready, 1'b1);

        // Two-word load
        s1 = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
               8'h55, 8'h66, 8'h77, 8'h88};
        for (int i = 0; i < 10; i++) begin
            send(s1[i], 0);
            if (i == 1) check("hdr_psel", done, 1'b0);
        end
        wait_done();
        check("two_nwr", wa.size(), 2);
        if (wa.size() == 2) begin
            check("two_a0", wa[0], 11'd0);
            check("two_d0", wd[0], 32'h44332211);
            check("two_m0", wm[0], 4'hF);
            check("two_a1", wa[1], 11'd1);
            check("two_d1", wd[1], 32'h88776655);
        end
        check("two_psel", port_select, 1'b0);
        check("two_cpurst", cpu_reset, 1'b0);
        rx_valid = 1'b1;
        #1;
        check("two_rdy_done", rx_ready, 1'b0);
        rx_valid = 1'b0;

        // Skip load
        skip_load = 1'b1;
        do_reset();
        rx_valid = 1'b1;
        rx_data  = 8'h5A;
        #1;
        check("skip_rdy", rx_ready, 1'b0);
        check("skip_done0", done, 1'b0);
        @(posedge clk);
        #1;
        check("skip_done1", done, 1'b1);
        check("skip_psel", port_select, 1'b0);
        check("skip_rdy2", rx_ready, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("skip_nwr", wa.size(), 0);
        rx_valid  = 1'b0;
        skip_load = 1'b0;

        // Zero count
        do_reset();
        send(8'h00, 0);
        send(8'h00, 0);
        check("zero_done", done, 1'b1);
        check("zero_cpurst", cpu_reset, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("zero_nwr", wa.size(), 0);

        // Full memory (count clamped to 2048)
        do_reset();
        send(8'hFF, 0);
        send(8'hFF, 0);
        for (int w = 0; w < 2048; w++) begin
            send(8'(w), 0);
            send(8'(w >> 8), 0);
            send(8'hA5, 0);
            send(8'h5A, 0);
        end
        wait_done();
        check("full_nwr", wa.size(), 2048);
        ea = 0;
        ed = 0;
        for (int i = 0; i < wa.size(); i++) begin
            if (wa[i] !== 11'(i)) ea++;
            if (wd[i] !== {8'h5A, 8'hA5, 8'(i >> 8), 8'(i)}) ed++;
        end
        check("full_addr_errs", ea, 0);
        check("full_data_errs", ed, 0);
        rx_valid = 1'b1;
        rx_data  = 8'h33;
        #1;
        check("full_rdy_done", rx_ready, 1'b0);
        rx_valid = 1'b0;

        // Three words with random valid gaps
        do_reset();
        s3 = '{8'h03, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
               8'h10, 8'h20, 8'h30, 8'h40,
               8'hAA, 8'hBB, 8'hCC, 8'hDD};
        for (int i = 0; i < 14; i++) begin
            send(s3[i], int'($urandom_range(0, 3)));
        end
        wait_done();
        check("gap_nwr", wa.size(), 3);
        if (wa.size() == 3) begin
            check("gap_a0", wa[0], 11'd0);
            check("gap_d0", wd[0], 32'h04030201);
            check("gap_a1", wa[1], 11'd1);
            check("gap_d1", wd[1], 32'h40302010);
            check("gap_a2", wa[2], 11'd2);
            check("gap_d2", wd[2], 32'hDDCCBBAA);
        end

        // Reset in the middle of word 1
        do_reset();
        for (int i = 0; i < 8; i++) begin
            b = s1[i];
            send(b, 0);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("mid_psel", port_select, 1'b1);
        check("mid_cpurst", cpu_reset, 1'b1);
        check("mid_done", done, 1'b0);
        check("mid_rdy", rx_ready, 1'b1);
        wa.delete();
        wd.delete();
        wm.delete();
        send(8'h01, 0);
        send(8'h00, 0);
        send(8'hDE, 0);
        send(8'hAD, 0);
        send(8'hBE, 0);
        send(8'hEF, 0);
        wait_done();
        check("mid_nwr", wa.size(), 1);
        if (wa.size() == 1) begin
            check("mid_a0", wa[0], 11'd0);
            check("mid_d0", wd[0], 32'hEFBEADDE);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 Parameter NUM_WMASKS, default 4, number of byte write-mask bits per word.
REQ-002 Parameter DATA_WIDTH, default 32, memory word width; SHALL equal 8*NUM_WMASKS.
REQ-003 Parameter ADDR_WIDTH, default 11, memory word-address width.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 skip_load  input  1  request to bypass loading; sampled only in HDR_LO.
REQ-007 rx_data  input  8  byte stream data.
REQ-008 rx_valid  input  1  rx_data is valid.
REQ-009 rx_ready  output  1  loader accepts a byte; transfer when rx_valid && rx_ready at a clock edge.
REQ-010 port_select  output  1  drives the memory port switch; 1 = loader owns the R/W memory port.
REQ-011 mem_web  output  1  active-low write enable, to switch input port 1.
REQ-012 mem_wmask  output  NUM_WMASKS  byte write mask.
REQ-013 mem_addr  output  ADDR_WIDTH  word address.
REQ-014 mem_din  output  DATA_WIDTH  write data.
REQ-015 cpu_reset  output  1  active-high reset held on the CPU until loading completes.
REQ-016 done  output  1  high once loading is finished or skipped.

Function
REQ-017 The stream format SHALL be: count low byte, count high byte (16-bit word count N), then N words, each sent as 4 bytes, least-significant byte first.
REQ-018 States SHALL be HDR_LO, HDR_HI, DATA, WRITE, DONE; all outputs registered or decoded from state only.
REQ-019 HDR_LO: rx_ready = !skip_load; skip_load high -> DONE with no byte consumed; otherwise an accepted byte loads count[7:0] and moves to HDR_HI.
REQ-020 HDR_HI: an accepted byte loads count[15:8]; effective count = min(N, 2^ADDR_WIDTH); effective count 0 -> DONE, else DATA with word index 0 and byte index 0.
REQ-021 DATA: rx_ready = 1; each accepted byte goes to lane byte index; the 4th byte (index 3) moves to WRITE.
REQ-022 WRITE: exactly one cycle with mem_web = 0, mem_wmask = all ones, mem_addr = word index, mem_din = assembled word; rx_ready = 0.
REQ-023 After WRITE: word index increments; if the incremented index equals the effective count -> DONE, else DATA.
REQ-024 Outside WRITE: mem_web = 1, mem_wmask = 0, mem_addr = 0, mem_din = 0.
REQ-025 port_select = 1 and cpu_reset = 1 in every state except DONE; in DONE port_select = 0, cpu_reset = 0, done = 1, rx_ready = 0.
REQ-026 DONE SHALL be terminal until reset; excess stream bytes are not consumed.
REQ-027 Stalls (rx_valid low) in any state SHALL hold all state with no memory write.
REQ-028 Word index SHALL be ADDR_WIDTH+1 bits so a 2^ADDR_WIDTH load terminates without wrap.

Reset
REQ-029 reset high SHALL force HDR_LO, count/indices/assembly register to 0, port_select = 1, cpu_reset = 1, done = 0, mem_web = 1, and all other outputs to 0; this applies from any state, including mid-word and during WRITE (write aborted).

Structure
REQ-030 Package mem_loader_pkg SHALL hold the state enum and the header byte count constant (2).
REQ-031 Byte-to-word assembly SHALL be a sub-module byte_packer (byte in, lane index, word out); the FSM stays in mem_loader.

Verification
REQ-032 Count 0x0002, bytes 11 22 33 44 55 66 77 88 -> writes 0x44332211 @0 and 0x88776655 @1, then port_select = 0, cpu_reset = 0, done = 1.
REQ-033 skip_load = 1 after reset -> DONE the next cycle, no mem_web pulse, rx_valid byte not consumed.
REQ-034 Count 0x0000 -> DONE directly after the second header byte, no writes.
REQ-035 Count 0xFFFF with ADDR_WIDTH = 11 -> exactly 2048 writes, addresses 0..2047, then DONE, further bytes see rx_ready = 0.
REQ-036 Random rx_valid gaps during a 3-word load -> identical writes to the gap-free run, one mem_web pulse per word.
REQ-037 reset asserted after the 2nd byte of word 1 -> HDR_LO, port_select = 1, cpu_reset = 1; a fresh stream then loads correctly from address 0.
